posit_mult_pipe: RTL and testbench

- Parametrised, pipelined posit multiplier. Successor to the combinational PAU multiplier, now with configurable N/ES.
- Has a 3-stage pipeline with valid/ready handshakes on both sides and a sideband tag.
- Correct zero/NaR semantics and saturating round-to-nearest-even.
- Sits in the PAU datapath between the operand-issue logic and the result writeback/arbiter.

---
 rtl/posit_pkg.sv | 43 ++++
 rtl/posit_mult_pipe_if.sv | 27 ++
 rtl/posit_decode.sv | 55 +++++
 rtl/posit_mult_pipe.sv | 179 +++++++++++++++++
 tb/tb_posit_mult_pipe.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/posit_pkg.sv
// Shared helpers for the pipelined posit multiplier: width arithmetic and the
// special bit patterns, all as functions of the posit width.
package posit_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Regime-count width, fraction width and signed scale width for (n, es).
    function automatic int bs_w(input int n);
        return clog2(n);
    endfunction

    function automatic int fw_w(input int n, input int es);
        return n - es - 2;
    endfunction

    function automatic int scw_w(input int n, input int es);
        return clog2(n) + es + 2;
    endfunction

    function automatic logic [31:0] nar_pat(input int n);
        return 32'(1) << (n - 1);
    endfunction

    function automatic logic [31:0] zero_pat(input int n);
        return (n > 0) ? 32'd0 : 32'd0;
    endfunction

    function automatic logic [31:0] maxpos_pat(input int n);
        return (32'(1) << (n - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] minpos_pat(input int n);
        return (n > 0) ? 32'd1 : 32'd0;
    endfunction

endpackage

// File: rtl/posit_mult_pipe_if.sv
// Operand-issue and result handshake bundle of the posit multiplier.
interface posit_mult_pipe_if #(
    parameter int N     = 16,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_p;
    logic             out_nar;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_nar, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_nar, out_zero, out_tag
    );
endinterface

// File: rtl/posit_decode.sv
// Combinational posit field decoder: specials, sign, regime k, exponent and
// fraction (hidden bit not included) of the operand magnitude.
module posit_decode
    import posit_pkg::*;
#(
    parameter int N  = 16,
    parameter int ES = 1,
    localparam int BS = bs_w(N),
    localparam int FW = fw_w(N, ES),
    localparam int EW = (ES > 0) ? ES : 1
) (
    input  logic [N-1:0]       i_p,
    output logic               o_nar,
    output logic               o_zero,
    output logic               o_sign,
    output logic signed [BS:0] o_k,
    output logic [EW-1:0]      o_exp,
    output logic [FW-1:0]      o_frac
);
    localparam logic [N-1:0] P_NAR = N'(nar_pat(N));

    logic [N-2:0]       w_mag;
    logic [BS-1:0]      w_run;
    logic               w_done;
    logic signed [BS:0] w_runs;
    logic [N-3:0]       w_rem;

    assign o_nar  = (i_p == P_NAR);
    assign o_zero = (i_p == '0);
    assign o_sign = i_p[N-1];

    always_comb begin
        w_mag  = i_p[N-1] ? (~i_p[N-2:0] + (N-1)'(1)) : i_p[N-2:0];
        w_run  = '0;
        w_done = 1'b0;
        // Regime: run of bits equal to the first one after the sign.
        for (int i = N - 2; i >= 0; i--) begin
            if (!w_done && (w_mag[i] == w_mag[N-2])) w_run = w_run + BS'(1);
            else                                     w_done = 1'b1;
        end
        w_runs = $signed({1'b0, w_run});
        o_k    = w_mag[N-2] ? (w_runs - (BS+1)'(1)) : -w_runs;
        // Drop the run and its terminator; exponent and fraction follow.
        w_rem  = w_mag[N-3:0] << w_run;
    end

    if (ES > 0) begin : g_exp
        assign o_exp = w_rem[N-3 -: EW];
    end else begin : g_noexp
        assign o_exp = '0;
    end

    assign o_frac = w_rem[FW-1:0];

endmodule

// File: rtl/posit_mult_pipe.sv
// Three-stage posit multiplier (decode, multiply, normalise/round/pack) with
// valid/ready on both sides and a tag that travels with each operation.
module posit_mult_pipe
    import posit_pkg::*;
#(
    parameter int N     = 16,
    parameter int ES    = 1,
    parameter int TAG_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    posit_mult_pipe_if.slave io
);
    localparam int BS  = bs_w(N);
    localparam int FW  = fw_w(N, ES);
    localparam int SCW = scw_w(N, ES);
    localparam int EW  = (ES > 0) ? ES : 1;
    localparam int HW  = FW + 1;
    localparam int PW  = 2 * HW;
    localparam int FW2 = PW - 1;
    localparam int BW  = ES + FW2;
    localparam int TW  = BW + 2 + N;

    localparam logic [N-1:0] P_NAR    = N'(nar_pat(N));
    localparam logic [N-1:0] P_ZERO   = N'(zero_pat(N));
    localparam logic [N-1:0] P_MAXPOS = N'(maxpos_pat(N));
    localparam logic [N-1:0] P_MINPOS = N'(minpos_pat(N));
    localparam logic signed [SCW-1:0] KMAX = SCW'(N - 2);
    localparam logic signed [SCW-1:0] KMIN = SCW'(2 - N);

    // Handshake: a stage loads when empty or when its contents move on.
    logic r_rdy_en, r_vld_p1, r_vld_p2, r_vld_p3;
    logic w_adv1, w_adv2, w_adv3, w_load;

    assign w_adv3      = r_vld_p3 & io.out_ready;
    assign w_adv2      = r_vld_p2 & (~r_vld_p3 | w_adv3);
    assign w_adv1      = r_vld_p1 & (~r_vld_p2 | w_adv2);
    assign io.in_ready = r_rdy_en & (~r_vld_p1 | w_adv1);
    assign w_load      = io.in_valid & io.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_load)      r_vld_p1 <= 1'b1;
            else if (w_adv1) r_vld_p1 <= 1'b0;
            if (w_adv1)      r_vld_p2 <= 1'b1;
            else if (w_adv2) r_vld_p2 <= 1'b0;
            if (w_adv2)      r_vld_p3 <= 1'b1;
            else if (w_adv3) r_vld_p3 <= 1'b0;
        end
    end

    // ---- Stage 1: decode both operands
    logic               w_na, w_nb, w_za, w_zb, w_sa, w_sb;
    logic signed [BS:0] w_ka, w_kb;
    logic [EW-1:0]      w_ea, w_eb;
    logic [FW-1:0]      w_fa, w_fb;

    posit_decode #(.N(N), .ES(ES)) u_dec_a (
        .i_p(io.in_a), .o_nar(w_na), .o_zero(w_za), .o_sign(w_sa),
        .o_k(w_ka), .o_exp(w_ea), .o_frac(w_fa)
    );
    posit_decode #(.N(N), .ES(ES)) u_dec_b (
        .i_p(io.in_b), .o_nar(w_nb), .o_zero(w_zb), .o_sign(w_sb),
        .o_k(w_kb), .o_exp(w_eb), .o_frac(w_fb)
    );

    logic               r_nar_p1, r_zero_p1, r_sa_p1, r_sb_p1;
    logic signed [BS:0] r_ka_p1, r_kb_p1;
    logic [EW-1:0]      r_ea_p1, r_eb_p1;
    logic [FW-1:0]      r_fa_p1, r_fb_p1;
    logic [TAG_W-1:0]   r_tag_p1;

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_nar_p1  <= w_na | w_nb;
            r_zero_p1 <= w_za | w_zb;
            r_sa_p1   <= w_sa;
            r_sb_p1   <= w_sb;
            r_ka_p1   <= w_ka;
            r_kb_p1   <= w_kb;
            r_ea_p1   <= w_ea;
            r_eb_p1   <= w_eb;
            r_fa_p1   <= w_fa;
            r_fb_p1   <= w_fb;
            r_tag_p1  <= io.in_tag;
        end
    end

    // ---- Stage 2: fraction product and combined scale
    logic [PW-1:0]         w_prod;
    logic signed [SCW-1:0] w_ksum, w_scale;

    assign w_prod  = PW'({1'b1, r_fa_p1}) * PW'({1'b1, r_fb_p1});
    assign w_ksum  = SCW'(r_ka_p1) + SCW'(r_kb_p1);
    assign w_scale = (w_ksum <<< ES) + SCW'(r_ea_p1) + SCW'(r_eb_p1);

    logic                  r_sign_p2, r_nar_p2, r_zero_p2;
    logic [PW-1:0]         r_prod_p2;
    logic signed [SCW-1:0] r_scale_p2;
    logic [TAG_W-1:0]      r_tag_p2;

    always_ff @(posedge clk) begin
        if (w_adv1) begin
            r_sign_p2  <= r_sa_p1 ^ r_sb_p1;
            r_nar_p2   <= r_nar_p1;
            r_zero_p2  <= ~r_nar_p1 & r_zero_p1;
            r_prod_p2  <= w_prod;
            r_scale_p2 <= w_scale;
            r_tag_p2   <= r_tag_p1;
        end
    end

    // ---- Stage 3: normalise, regime/exponent split, round, saturate, pack
    logic                  w_ovf, w_sat_hi, w_sat_lo, w_g, w_r, w_s, w_ulp;
    logic [FW2-1:0]        w_nfrac;
    logic signed [SCW-1:0] w_nscale, w_k3;
    logic [EW-1:0]         w_e3;
    logic [SCW-1:0]        w_sh;
    logic [BW-1:0]         w_body;
    logic signed [TW-1:0]  w_word, w_shifted;
    logic [N-2:0]          w_mag3, w_rnd, w_abs;
    logic [N-1:0]          w_res, w_p3;

    assign w_ovf    = r_prod_p2[PW-1];
    assign w_nfrac  = w_ovf ? r_prod_p2[PW-2:0] : {r_prod_p2[PW-3:0], 1'b0};
    assign w_nscale = r_scale_p2 + SCW'(w_ovf);
    assign w_k3     = w_nscale >>> ES;
    assign w_e3     = w_nscale[EW-1:0];
    assign w_sat_hi = (w_k3 >= KMAX);
    assign w_sat_lo = (w_k3 < KMIN);
    // Regime length minus two: k for positive k, -k-1 for negative k.
    assign w_sh     = w_k3[SCW-1] ? ~w_k3 : w_k3;

    if (ES > 0) begin : g_body_exp
        assign w_body = {w_e3, w_nfrac};
    end else begin : g_body_noexp
        assign w_body = w_nfrac;
    end

    assign w_word    = $signed({(w_k3[SCW-1] ? 2'b01 : 2'b10), w_body, {N{1'b0}}});
    assign w_shifted = w_word >>> w_sh;
    assign w_mag3    = w_shifted[TW-1 -: N-1];
    assign w_g       = w_shifted[TW-N];
    assign w_r       = w_shifted[TW-N-1];
    assign w_s       = |w_shifted[TW-N-2:0];
    assign w_ulp     = (w_g & (w_r | w_s)) | (w_mag3[0] & w_g & ~(w_r | w_s));
    assign w_rnd     = w_mag3 + (N-1)'(w_ulp);
    assign w_abs     = w_sat_hi ? P_MAXPOS[N-2:0] :
                       w_sat_lo ? P_MINPOS[N-2:0] : w_rnd;
    assign w_res     = r_sign_p2 ? -{1'b0, w_abs} : {1'b0, w_abs};
    assign w_p3      = r_nar_p2 ? P_NAR : (r_zero_p2 ? P_ZERO : w_res);

    logic [N-1:0]     r_p_p3;
    logic             r_nar_p3, r_zero_p3;
    logic [TAG_W-1:0] r_tag_p3;

    always_ff @(posedge clk) begin
        if (w_adv2) begin
            r_p_p3    <= w_p3;
            r_nar_p3  <= r_nar_p2;
            r_zero_p3 <= r_zero_p2;
            r_tag_p3  <= r_tag_p2;
        end
    end

    // Data registers are not reset; gating by the valid bit keeps outputs at 0.
    assign io.out_valid = r_vld_p3;
    assign io.out_p     = r_vld_p3 ? r_p_p3 : '0;
    assign io.out_nar   = r_vld_p3 & r_nar_p3;
    assign io.out_zero  = r_vld_p3 & r_zero_p3;
    assign io.out_tag   = r_vld_p3 ? r_tag_p3 : '0;

endmodule

// File: tb/tb_posit_mult_pipe.sv
// Scoreboard bench for posit_mult_pipe (N=16, ES=1): directed vectors with
// hand-computed products, throughput, backpressure and mid-flight reset.
module tb_posit_mult_pipe;
    localparam int N     = 16;
    localparam int ES    = 1;
    localparam int TAG_W = 4;
    localparam int NV    = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    posit_mult_pipe_if #(.N(N), .TAG_W(TAG_W)) io ();
    posit_mult_pipe #(.N(N), .ES(ES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .io(io)
    );

    typedef struct {
        logic [N-1:0]     p;
        logic             nar;
        logic             zero;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        logic        nar;
        logic        zero;
    } vec_t;

    vec_t vt [NV] = '{
        '{16'h4000, 16'h4000, 16'h4000, 1'b0, 1'b0},  // 1*1
        '{16'h5000, 16'h5000, 16'h6000, 1'b0, 1'b0},  // 2*2
        '{16'hC000, 16'h5000, 16'hB000, 1'b0, 1'b0},  // -1*2
        '{16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b0},  // NaR*0
        '{16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1},  // 0*1
        '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0},  // maxpos^2 clamps
        '{16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b0},  // minpos^2 clamps
        '{16'h8001, 16'h7FFF, 16'h8001, 1'b0, 1'b0},  // -maxpos*maxpos
        '{16'h4800, 16'h4800, 16'h5200, 1'b0, 1'b0},  // 1.5^2=2.25
        '{16'h4400, 16'h4400, 16'h4900, 1'b0, 1'b0},  // 1.25^2=1.5625
        '{16'h4001, 16'h4001, 16'h4002, 1'b0, 1'b0},  // sticky only, round down
        '{16'h4001, 16'h4800, 16'h4802, 1'b0, 1'b0},  // tie, odd -> up
        '{16'h4003, 16'h4800, 16'h4804, 1'b0, 1'b0},  // tie, even -> stay
        '{16'h7FFF, 16'h3000, 16'h7FFE, 1'b0, 1'b0},  // exponent bit is guard
        '{16'hB000, 16'hC000, 16'h5000, 1'b0, 1'b0},  // -2*-1
        '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b0},  // 0*NaR
        '{16'h0000, 16'hC000, 16'h0000, 1'b0, 1'b1}   // 0*-1
    };

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int stalls = 0;
    int nres   = 0;
    int npush  = 0;
    logic [N-1:0]     hold_p;
    logic [TAG_W-1:0] hold_tag;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && io.out_valid && io.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got p=%0h tag=%0h, want no output", io.out_p, io.out_tag);
            end else begin
                e = q.pop_front();
                nres++;
                chk("out_p",    32'(io.out_p),    32'(e.p));
                chk("out_nar",  32'(io.out_nar),  32'(e.nar));
                chk("out_zero", 32'(io.out_zero), 32'(e.zero));
                chk("out_tag",  32'(io.out_tag),  32'(e.tag));
                if (e.cyc >= 0) chk("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic send(input vec_t v, input logic [TAG_W-1:0] tag, input bit lat, input bit push);
        int   n;
        exp_t e;
        n = 0;
        io.in_valid = 1'b1;
        io.in_a     = v.a;
        io.in_b     = v.b;
        io.in_tag   = tag;
        @(negedge clk);
        while (!io.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        stalls += n;
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %0b, want 1", io.in_ready);
        end else if (push) begin
            e.p = v.p; e.nar = v.nar; e.zero = v.zero; e.tag = tag;
            e.cyc = lat ? cyc + 3 : -1;
            q.push_back(e);
            npush++;
        end
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        io.in_valid  = 1'b0;
        io.in_a      = '0;
        io.in_b      = '0;
        io.in_tag    = '0;
        io.out_ready = 1'b1;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(io.out_valid), 32'd0);
        chk("rst_out_p",     32'(io.out_p),     32'd0);
        chk("rst_out_nar",   32'(io.out_nar),   32'd0);
        chk("rst_out_zero",  32'(io.out_zero),  32'd0);
        chk("rst_out_tag",   32'(io.out_tag),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 32'(io.in_ready), 32'd1);

        // Directed vectors, issued back to back with latency checking.
        for (int i = 0; i < NV; i++) send(vt[i], TAG_W'(i), 1'b1, 1'b1);
        drain();

        // Eight consecutive ops with unique tags: no stall allowed.
        stalls = 0;
        for (int i = 0; i < 8; i++) send(vt[(i * 3) % NV], TAG_W'(i + 8), 1'b1, 1'b1);
        chk("b2b_stall_cycles", 32'(stalls), 32'd0);
        drain();

        // Backpressure: three ops fill the pipe, the fourth must wait.
        io.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(vt[i + 8], TAG_W'(i + 1), 1'b0, 1'b1);
        io.in_valid = 1'b1;
        io.in_a     = vt[2].a;
        io.in_b     = vt[2].b;
        io.in_tag   = 4'hA;
        @(negedge clk);
        chk("bp_in_ready_low", 32'(io.in_ready),  32'd0);
        chk("bp_out_valid",    32'(io.out_valid), 32'd1);
        hold_p   = io.out_p;
        hold_tag = io.out_tag;
        @(negedge clk);
        chk("bp_in_ready_low", 32'(io.in_ready), 32'd0);
        chk("bp_hold_p",       32'(io.out_p),    32'(hold_p));
        chk("bp_hold_tag",     32'(io.out_tag),  32'(hold_tag));
        @(posedge clk);
        #1;
        io.out_ready = 1'b1;
        send(vt[2], 4'hA, 1'b0, 1'b1);
        drain();

        // Reset with three ops in flight: nothing from them may emerge.
        for (int i = 0; i < 3; i++) send(vt[i + 1], TAG_W'(i + 12), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_flush_out_valid", 32'(io.out_valid), 32'd0);
        @(negedge clk);
        chk("rst_hold_out_valid", 32'(io.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_flush", 32'(io.in_ready), 32'd1);
        send(vt[1], 4'hF, 1'b1, 1'b1);
        drain();
        repeat (6) @(posedge clk);

        chk("result_count", 32'(nres), 32'(npush));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
